spi_target_regbank: RTL and testbench
=====================================

// Module: spi_target_regbank
// PURPOSE
// - Target (chip-side) end of the control-board SPI link: decodes write/read frames and serves a local 8-bit register bank.
// - Used as an on-FPGA loopback target and chip stand-in for validating the SPI driver path.
// - Serial lines are oversampled on one system clock; there is no chip select, so frames are delimited by spi_clk idle timeout.
// PARAMETERS
// - N_REGS       64   number of implemented 8-bit registers, addresses 0..N_REGS-1 (1..256)
// - IDLE_TIMEOUT 64   clk cycles with no spi_clk edge that end the current frame (>=8)
// PORTS
// - clk         in   1  system clock (~40 MHz), the only clock
// - rstn        in   1  synchronous, active-low reset
// - spi_clk     in   1  SPI clock from the driver, async; idles low; max freq clk/8
// - serial_in   in   1  driver->target data, sampled on spi_clk rising edge, MSB first
// - serial_out  out  1  target->driver data, changed after spi_clk falling edge, MSB first
// - wr_strobe   out  1  one-cycle pulse when a register write commits
// - wr_addr     out  8  address of committed write, valid with wr_strobe
// - wr_data     out  8  data of committed write, valid with wr_strobe
// - dbg_addr    in   8  local read-back address
// - dbg_data    out  8  regs[dbg_addr] (0x00 if out of range), registered, 1-cycle latency
// - frame_err   out  1  one-cycle pulse: bad command byte or truncated frame
// - addr_err    out  1  sticky: any access to address >= N_REGS; cleared only by rstn
// - busy        out  1  high from first spi_clk edge of a frame until frame end
// BEHAVIOUR
// - Reset (rstn=0 at clk edge): all regs 0x00, FSM=CMD, bit counter 0, timeout counter 0; serial_out=0, wr_strobe=0,
//   wr_addr=0, wr_data=0, dbg_data=0, frame_err=0, addr_err=0, busy=0. Reset mid-frame aborts the frame with no write.
// - spi_clk and serial_in each pass a 2-FF synchronizer; one more register gives edge detect. Rise/fall seen 3 clk after pin.
// - Shift register collects 8 bits on detected rises; byte complete on the 8th rise.
// - Frame formats (bytes): write = 0x01, ADDR, DATA; read = 0x02, START, COUNT, then COUNT bytes out.
// - FSM states: CMD -> ADDR -> ARG -> (write: DONE) / (read: RD_DATA -> DONE); any state -> DISCARD on error.
//   CMD: 0x01/0x02 -> ADDR; other value -> frame_err pulse, DISCARD.
//   ARG write: on DATA byte complete, if ADDR<N_REGS regs[ADDR]<=DATA and wr_strobe pulses next clk; else addr_err<=1, no strobe.
//   ARG read: COUNT=0 -> DONE; else load regs[START] into tx shift reg, -> RD_DATA.
//   RD_DATA: on each detected fall shift next bit to serial_out (first fall after COUNT byte drives MSB of byte 0).
//     After each 8 output bits, address+1 (mod 256); next byte loaded. Out-of-range address returns 0x00, sets addr_err.
//     After COUNT bytes -> DONE. Only 8-bit count: max 255 bytes.
//   DONE/DISCARD: further edges ignored, serial_out held 0.
// - Frame end: timeout counter resets on every detected edge, increments otherwise; at IDLE_TIMEOUT -> CMD, bit count 0,
//   busy=0, serial_out=0. If the frame ends in ADDR, ARG, RD_DATA, or mid-byte, frame_err pulses once (no write).
// - The bank is written only by SPI; simultaneous dbg read and SPI write of the same address returns old value.
// CONFIGURATION
// - SPI_TARGET_WRAP_EN defined: read burst address wraps from N_REGS-1 to 0; bursts never set addr_err past the top
//   (START>=N_REGS still sets it).
// - Not defined: address increments mod 256; addresses >=N_REGS return 0x00 and set addr_err.
// TESTING
// - Write 0x01,0x05,0xA7 -> wr_strobe once with addr 0x05 data 0xA7; dbg_addr=5 gives 0xA7; frame_err=0.
// - Preload regs 3..5=0x11,0x22,0x33; read 0x02,0x03,0x03 -> serial_out bytes 0x11,0x22,0x33 then 0x00.
// - Command 0x7F -> frame_err pulse; following bytes 0x01,0x05,0xFF cause no write; after timeout, next frame works.
// - N_REGS=64, read 0x02,0x3F,0x02 -> 0x00-path: reg63 value then 0x00, addr_err=1; with SPI_TARGET_WRAP_EN: reg63, reg0, addr_err=0.
// - Write 0x01,0x05 then idle IDLE_TIMEOUT clks -> frame_err pulse, no wr_strobe, busy falls, regs unchanged.
// - rstn low after 12 bits of a write frame -> all outputs reset, regs 0x00; fresh frame after release decodes correctly.

Source files
------------

// File: rtl/spi_target_regbank.sv
// spi_target_regbank
//   SPI target end of the control-board link. The serial lines are oversampled
//   on clk; there is no chip select, so a frame ends after IDLE_TIMEOUT clk
//   cycles without any spi_clk edge. The block decodes write frames
//   (0x01, ADDR, DATA) and read frames (0x02, START, COUNT, then COUNT bytes
//   out), and serves a bank of N_REGS 8-bit registers.
//
//   Build option: define SPI_TARGET_WRAP_EN to make read bursts wrap from
//   N_REGS-1 to 0. Without it, burst addresses increment mod 256, and any
//   address >= N_REGS reads as 0x00 and sets addr_err.
//
// Ports
//   clk        in   system clock, the only clock
//   rstn       in   synchronous active-low reset
//   spi_clk    in   asynchronous SPI clock, idles low
//   serial_in  in   driver->target data, sampled on spi_clk rise, MSB first
//   serial_out out  target->driver data, updated after spi_clk fall, MSB first
//   wr_strobe  out  one-cycle pulse when a register write commits
//   wr_addr    out  [7:0] address of the committed write
//   wr_data    out  [7:0] data of the committed write
//   dbg_addr   in   [7:0] local read-back address
//   dbg_data   out  [7:0] regs[dbg_addr], or 0x00 if out of range (1-cycle latency)
//   frame_err  out  one-cycle pulse: bad command byte or truncated frame
//   addr_err   out  sticky flag: an access touched an address >= N_REGS
//   busy       out  high from the first spi_clk edge until the frame ends
module spi_target_regbank #(
  parameter int N_REGS       = 64,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_clk,
  input  logic       serial_in,
  output logic       serial_out,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       frame_err,
  output logic       addr_err,
  output logic       busy
);

  localparam logic [8:0] N_REGS_W = 9'(N_REGS);
  localparam int         TW       = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_ARG, ST_RD_DATA, ST_DONE, ST_DISCARD
  } state_t;

  state_t state_reg, state_next;

  // synchronizers and edge-detect stage
  logic sclk_s1_reg, sclk_s2_reg, sclk_s3_reg;
  logic sdi_s1_reg, sdi_s2_reg;

  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic          is_read_reg, is_read_next;
  logic [7:0]    addr_reg, addr_next;
  logic [7:0]    rd_addr_reg, rd_addr_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    bytes_left_reg, bytes_left_next;
  logic          serial_out_reg, serial_out_next;
  logic          wr_strobe_reg, wr_strobe_next;
  logic [7:0]    wr_addr_reg, wr_addr_next;
  logic [7:0]    wr_data_reg, wr_data_next;
  logic          frame_err_reg, frame_err_next;
  logic          addr_err_reg, addr_err_next;
  logic          busy_reg, busy_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [7:0]    dbg_data_reg;
  logic          reg_we;

  logic [N_REGS*8-1:0] regs_flat;

  logic       rise, fall, any_edge;
  logic [7:0] byte_in;
  logic [7:0] next_rd_addr;
  logic [7:0] start_val, next_val;

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < N_REGS_W;
  endfunction

  function automatic logic [7:0] reg_read(input logic [7:0] a);
    if (in_range(a)) return regs_flat[{a, 3'b000} +: 8];
    return 8'h00;
  endfunction

  // register bank: one resettable byte per implemented address
  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_reg
      logic [7:0] r;
      always_ff @(posedge clk) begin
        if (!rstn) r <= 8'h00;
        else if (reg_we && addr_reg == 8'(gi)) r <= byte_in;
      end
      assign regs_flat[gi*8 +: 8] = r;
    end
  endgenerate

  assign rise     = sclk_s2_reg & ~sclk_s3_reg;
  assign fall     = ~sclk_s2_reg & sclk_s3_reg;
  assign any_edge = rise | fall;
  // serial_in has the same sync depth as spi_clk, so s2 lines up with the rise
  assign byte_in  = {rx_shift_reg[6:0], sdi_s2_reg};

`ifdef SPI_TARGET_WRAP_EN
  assign next_rd_addr = ({1'b0, rd_addr_reg} >= N_REGS_W - 9'd1) ? 8'h00 : rd_addr_reg + 8'd1;
`else
  assign next_rd_addr = rd_addr_reg + 8'd1;
`endif

  assign start_val = reg_read(addr_reg);
  assign next_val  = reg_read(next_rd_addr);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_s1_reg    <= 1'b0;
      sclk_s2_reg    <= 1'b0;
      sclk_s3_reg    <= 1'b0;
      sdi_s1_reg     <= 1'b0;
      sdi_s2_reg     <= 1'b0;
      state_reg      <= ST_CMD;
      bit_cnt_reg    <= 3'd0;
      rx_shift_reg   <= 8'h00;
      is_read_reg    <= 1'b0;
      addr_reg       <= 8'h00;
      rd_addr_reg    <= 8'h00;
      tx_shift_reg   <= 8'h00;
      tx_bit_reg     <= 3'd0;
      bytes_left_reg <= 8'h00;
      serial_out_reg <= 1'b0;
      wr_strobe_reg  <= 1'b0;
      wr_addr_reg    <= 8'h00;
      wr_data_reg    <= 8'h00;
      frame_err_reg  <= 1'b0;
      addr_err_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      tmo_cnt_reg    <= '0;
      dbg_data_reg   <= 8'h00;
    end else begin
      sclk_s1_reg    <= spi_clk;
      sclk_s2_reg    <= sclk_s1_reg;
      sclk_s3_reg    <= sclk_s2_reg;
      sdi_s1_reg     <= serial_in;
      sdi_s2_reg     <= sdi_s1_reg;
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      rx_shift_reg   <= rx_shift_next;
      is_read_reg    <= is_read_next;
      addr_reg       <= addr_next;
      rd_addr_reg    <= rd_addr_next;
      tx_shift_reg   <= tx_shift_next;
      tx_bit_reg     <= tx_bit_next;
      bytes_left_reg <= bytes_left_next;
      serial_out_reg <= serial_out_next;
      wr_strobe_reg  <= wr_strobe_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      frame_err_reg  <= frame_err_next;
      addr_err_reg   <= addr_err_next;
      busy_reg       <= busy_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      // reads the pre-write value when SPI writes the same address this cycle
      dbg_data_reg   <= reg_read(dbg_addr);
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    rx_shift_next   = rx_shift_reg;
    is_read_next    = is_read_reg;
    addr_next       = addr_reg;
    rd_addr_next    = rd_addr_reg;
    tx_shift_next   = tx_shift_reg;
    tx_bit_next     = tx_bit_reg;
    bytes_left_next = bytes_left_reg;
    serial_out_next = serial_out_reg;
    wr_strobe_next  = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    frame_err_next  = 1'b0;
    addr_err_next   = addr_err_reg;
    busy_next       = busy_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    reg_we          = 1'b0;

    if (any_edge) begin
      busy_next    = 1'b1;
      tmo_cnt_next = '0;
      case (state_reg)
        ST_CMD, ST_ADDR, ST_ARG: begin
          if (rise) begin
            rx_shift_next = byte_in;
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              case (state_reg)
                ST_CMD: begin
                  if (byte_in == 8'h01 || byte_in == 8'h02) begin
                    is_read_next = byte_in[1];
                    state_next   = ST_ADDR;
                  end else begin
                    frame_err_next = 1'b1;
                    state_next     = ST_DISCARD;
                  end
                end
                ST_ADDR: begin
                  addr_next  = byte_in;
                  state_next = ST_ARG;
                end
                default: begin
                  if (!is_read_reg) begin
                    if (in_range(addr_reg)) begin
                      reg_we         = 1'b1;
                      wr_strobe_next = 1'b1;
                      wr_addr_next   = addr_reg;
                      wr_data_next   = byte_in;
                    end else begin
                      addr_err_next = 1'b1;
                    end
                    state_next = ST_DONE;
                  end else if (byte_in == 8'h00) begin
                    state_next = ST_DONE;
                  end else begin
                    if (!in_range(addr_reg)) addr_err_next = 1'b1;
                    rd_addr_next    = addr_reg;
                    tx_shift_next   = start_val;
                    tx_bit_next     = 3'd0;
                    bytes_left_next = byte_in;
                    state_next      = ST_RD_DATA;
                  end
                end
              endcase
            end
          end
        end
        ST_RD_DATA: begin
          if (fall) begin
            serial_out_next = tx_shift_reg[7];
            tx_shift_next   = {tx_shift_reg[6:0], 1'b0};
            tx_bit_next     = tx_bit_reg + 3'd1;
            if (tx_bit_reg == 3'd7) begin
              bytes_left_next = bytes_left_reg - 8'd1;
              if (bytes_left_reg == 8'd1) begin
                // the LSB just driven stays up until the next fall clears it
                state_next = ST_DONE;
              end else begin
                rd_addr_next  = next_rd_addr;
                tx_shift_next = next_val;
                if (!in_range(next_rd_addr)) addr_err_next = 1'b1;
              end
            end
          end
        end
        default: begin
          if (fall) serial_out_next = 1'b0;
        end
      endcase
    end else if (busy_reg) begin
      if (tmo_cnt_reg == TMO_LAST) begin
        if (state_reg == ST_ADDR || state_reg == ST_ARG ||
            state_reg == ST_RD_DATA || bit_cnt_reg != 3'd0)
          frame_err_next = 1'b1;
        state_next      = ST_CMD;
        bit_cnt_next    = 3'd0;
        busy_next       = 1'b0;
        serial_out_next = 1'b0;
        tmo_cnt_next    = '0;
      end else begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
      end
    end
  end

  assign serial_out = serial_out_reg;
  assign wr_strobe  = wr_strobe_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign dbg_data   = dbg_data_reg;
  assign frame_err  = frame_err_reg;
  assign addr_err   = addr_err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_spi_target_regbank.sv
// tb_spi_target_regbank
//   Directed bench for spi_target_regbank: bit-bangs SPI frames at clk/16,
//   watches the pulse outputs with a monitor, and compares against
//   hand-computed values.
module tb_spi_target_regbank;

  localparam int N_REGS       = 64;
  localparam int IDLE_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_clk = 1'b0;
  logic       serial_in = 1'b0;
  logic       serial_out;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] dbg_addr = 8'h00;
  logic [7:0] dbg_data;
  logic       frame_err;
  logic       addr_err;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  int         strobe_cnt = 0;
  int         ferr_cnt   = 0;
  logic [7:0] last_waddr = 8'h00;
  logic [7:0] last_wdata = 8'h00;

  spi_target_regbank #(
    .N_REGS       (N_REGS),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_clk    (spi_clk),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .frame_err  (frame_err),
    .addr_err   (addr_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      last_waddr = wr_addr;
      last_wdata = wr_data;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one byte each way; serial_out is sampled just before each rise
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      serial_in = tx[i];
      clks(8);
      rx[i] = serial_out;
      spi_clk = 1'b1;
      clks(8);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      serial_in = tx[i];
      clks(8);
      spi_clk = 1'b1;
      clks(8);
      spi_clk = 1'b0;
    end
  endtask

  task automatic idle_wait();
    clks(IDLE_TIMEOUT + 12);
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rx;
    spi_byte(8'h01, rx);
    spi_byte(a, rx);
    spi_byte(d, rx);
    idle_wait();
  endtask

  task automatic dbg_rd(input logic [7:0] a, output logic [7:0] d);
    dbg_addr = a;
    clks(2);
    d = dbg_data;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] d;
    int s0, f0;

    dbg_addr = 8'h05;
    clks(4);
    check_vec("rst_serial_out", 32'(serial_out), 32'd0);
    check_vec("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check_vec("rst_frame_err", 32'(frame_err), 32'd0);
    check_vec("rst_addr_err", 32'(addr_err), 32'd0);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_dbg_data", 32'(dbg_data), 32'd0);
    rstn = 1'b1;
    clks(4);

    // basic write
    s0 = strobe_cnt; f0 = ferr_cnt;
    spi_byte(8'h01, rx);
    spi_byte(8'h05, rx);
    spi_byte(8'hA7, rx);
    check_vec("wr_busy_in_frame", 32'(busy), 32'd1);
    idle_wait();
    check_vec("wr_strobe_count", 32'(strobe_cnt - s0), 32'd1);
    check_vec("wr_addr", 32'(last_waddr), 32'h05);
    check_vec("wr_data", 32'(last_wdata), 32'hA7);
    check_vec("wr_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check_vec("wr_busy_after", 32'(busy), 32'd0);
    dbg_rd(8'h05, d);
    check_vec("wr_dbg5", 32'(d), 32'hA7);

    // burst read of 3..5
    spi_write(8'h03, 8'h11);
    spi_write(8'h04, 8'h22);
    spi_write(8'h05, 8'h33);
    f0 = ferr_cnt;
    spi_byte(8'h02, rx);
    spi_byte(8'h03, rx);
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx); check_vec("rd_byte0", 32'(rx), 32'h11);
    spi_byte(8'h00, rx); check_vec("rd_byte1", 32'(rx), 32'h22);
    spi_byte(8'h00, rx); check_vec("rd_byte2", 32'(rx), 32'h33);
    spi_byte(8'h00, rx); check_vec("rd_after_end", 32'(rx), 32'h00);
    idle_wait();
    check_vec("rd_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check_vec("rd_addr_err", 32'(addr_err), 32'd0);

    // bad command, then the rest of the frame is ignored
    s0 = strobe_cnt; f0 = ferr_cnt;
    spi_byte(8'h7F, rx);
    check_vec("badcmd_frame_err", 32'(ferr_cnt - f0), 32'd1);
    spi_byte(8'h01, rx);
    spi_byte(8'h05, rx);
    spi_byte(8'hFF, rx);
    idle_wait();
    check_vec("badcmd_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check_vec("badcmd_err_once", 32'(ferr_cnt - f0), 32'd1);
    dbg_rd(8'h05, d);
    check_vec("badcmd_reg5", 32'(d), 32'h33);
    spi_write(8'h06, 8'h5C);
    check_vec("badcmd_next_strobe", 32'(strobe_cnt - s0), 32'd1);
    dbg_rd(8'h06, d);
    check_vec("badcmd_next_reg6", 32'(d), 32'h5C);

    // truncated write frame
    s0 = strobe_cnt; f0 = ferr_cnt;
    spi_byte(8'h01, rx);
    spi_byte(8'h05, rx);
    idle_wait();
    check_vec("trunc_frame_err", 32'(ferr_cnt - f0), 32'd1);
    check_vec("trunc_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check_vec("trunc_busy", 32'(busy), 32'd0);
    dbg_rd(8'h05, d);
    check_vec("trunc_reg5", 32'(d), 32'h33);

    // burst across the top of the bank
    spi_write(8'h3F, 8'h9D);
    spi_write(8'h00, 8'h42);
    check_vec("top_addr_err_pre", 32'(addr_err), 32'd0);
    spi_byte(8'h02, rx);
    spi_byte(8'h3F, rx);
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx); check_vec("top_byte0", 32'(rx), 32'h9D);
    spi_byte(8'h00, rx);
`ifdef SPI_TARGET_WRAP_EN
    check_vec("top_byte1", 32'(rx), 32'h42);
    idle_wait();
    check_vec("top_addr_err", 32'(addr_err), 32'd0);
`else
    check_vec("top_byte1", 32'(rx), 32'h00);
    idle_wait();
    check_vec("top_addr_err", 32'(addr_err), 32'd1);
`endif

    // reset in the middle of a write frame
    s0 = strobe_cnt;
    spi_byte(8'h01, rx);
    spi_bits(8'h05, 4);
    rstn = 1'b0;
    dbg_addr = 8'h05;
    clks(3);
    rstn = 1'b1;
    clks(2);
    check_vec("mid_rst_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check_vec("mid_rst_busy", 32'(busy), 32'd0);
    check_vec("mid_rst_addr_err", 32'(addr_err), 32'd0);
    check_vec("mid_rst_serial_out", 32'(serial_out), 32'd0);
    check_vec("mid_rst_dbg5", 32'(dbg_data), 32'h00);
    f0 = ferr_cnt;
    spi_write(8'h07, 8'h3C);
    check_vec("post_rst_strobe", 32'(strobe_cnt - s0), 32'd1);
    check_vec("post_rst_wr_addr", 32'(last_waddr), 32'h07);
    check_vec("post_rst_wr_data", 32'(last_wdata), 32'h3C);
    check_vec("post_rst_frame_err", 32'(ferr_cnt - f0), 32'd0);
    dbg_rd(8'h07, d);
    check_vec("post_rst_reg7", 32'(d), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
